// File: rtl/regfile_pkg.sv
// Shared register-file types and defaults for decode, hazard unit and the register file itself.
package regfile_pkg;

  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_ADDR_W = 5;

  // Index of the hardwired zero register.
  localparam logic [REGFILE_ADDR_W-1:0] REG_ZERO = '0;

  typedef logic [REGFILE_ADDR_W-1:0] reg_idx_t;
  typedef logic [REGFILE_DATA_W-1:0] reg_word_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: write->read forwarding mux (wr1 over wr0 over array), zero-index masking,
// and busy gating so a result being forwarded this cycle is not reported as pending.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              arr_busy,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  logic hit0;
  logic hit1;
  logic is_zero;

  // Select forwarded or stored data; outputs are forced quiet while in reset.
  always_comb begin
    is_zero = (ZERO_REG != 0) && (rd_addr == ADDR_W'(REG_ZERO));
    hit1    = (BYPASS != 0) && wr1_en && (wr1_addr == rd_addr);
    hit0    = (BYPASS != 0) && wr0_en && (wr0_addr == rd_addr);
    rd_data = arr_data;
    if (hit1) begin
      rd_data = wr1_data;
    end else if (hit0) begin
      rd_data = wr0_data;
    end
    rd_busy = arr_busy && !hit0 && !hit1;
    if (is_zero || !rst_n) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports (wr1 has priority),
// asynchronous clear of array and busy scoreboard, optional zero register and write bypass.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic wr0_live;
  logic wr1_live;
  logic iss_live;

  // Drop writes and issues that target the hardwired zero register.
  always_comb begin
    wr0_live = wr0_en && !((ZERO_REG != 0) && (wr0_addr == ADDR_W'(REG_ZERO)));
    wr1_live = wr1_en && !((ZERO_REG != 0) && (wr1_addr == ADDR_W'(REG_ZERO)));
    iss_live = iss_en && !((ZERO_REG != 0) && (iss_addr == ADDR_W'(REG_ZERO)));
  end

  // Next array contents: wr1 applied last so it wins on an index collision.
  always_comb begin
    for (int n = 0; n < DEPTH; n++) begin
      regs_d[n] = regs_q[n];
    end
    if (wr0_live) begin
      regs_d[wr0_addr] = wr0_data;
    end
    if (wr1_live) begin
      regs_d[wr1_addr] = wr1_data;
    end
  end

  // Next scoreboard: writes retire a producer, an issue marks a new one; issue applied last so it wins.
  always_comb begin
    busy_d = busy_q;
    if (wr0_live) begin
      busy_d[wr0_addr] = 1'b0;
    end
    if (wr1_live) begin
      busy_d[wr1_addr] = 1'b0;
    end
    if (iss_live) begin
      busy_d[iss_addr] = 1'b1;
    end
  end

  // State registers with asynchronous clear; an edge taken while in reset is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < DEPTH; n++) begin
        regs_q[n] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int n = 0; n < DEPTH; n++) begin
        regs_q[n] <= regs_d[n];
      end
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_i;
    assign addr_i = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd_port (
      .rst_n    (rst_n),
      .rd_addr  (addr_i),
      .arr_data (regs_q[addr_i]),
      .arr_busy (busy_q[addr_i]),
      .wr0_en   (wr0_live),
      .wr0_addr (wr0_addr),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_live),
      .wr1_addr (wr1_addr),
      .wr1_data (wr1_data),
      .rd_data  (rd_data[i*DATA_W +: DATA_W]),
      .rd_busy  (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: instance a (4 read ports, zero reg, bypass) and instance b
// (2 read ports, no zero reg, no bypass) share clock, reset, write and issue inputs.
module tb_regfile_mp;
  import regfile_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic [19:0]  rd_addr_a;
  logic [127:0] rd_data_a;
  logic [3:0]   rd_busy_a;
  logic [9:0]   rd_addr_b;
  logic [63:0]  rd_data_b;
  logic [1:0]   rd_busy_b;
  logic         wr0_en;
  logic [4:0]   wr0_addr;
  logic [31:0]  wr0_data;
  logic         wr1_en;
  logic [4:0]   wr1_addr;
  logic [31:0]  wr1_data;
  logic         iss_en;
  logic [4:0]   iss_addr;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  // ---------------- scoreboard ----------------
  int checks;
  int failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic reg_word_t rda(input int i);
    return rd_data_a[i*32 +: 32];
  endfunction

  function automatic reg_word_t rdb(input int i);
    return rd_data_b[i*32 +: 32];
  endfunction

  function automatic logic [31:0] bsa(input int i);
    return {31'b0, rd_busy_a[i]};
  endfunction

  function automatic logic [31:0] bsb(input int i);
    return {31'b0, rd_busy_b[i]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_rda(input int i, input logic [4:0] a);
    rd_addr_a[i*5 +: 5] = a;
  endtask

  task automatic set_rdb(input int i, input logic [4:0] a);
    rd_addr_b[i*5 +: 5] = a;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic drive_wr0(input logic [4:0] a, input logic [31:0] d);
    wr0_en = 1'b1; wr0_addr = a; wr0_data = d;
  endtask

  task automatic drive_wr1(input logic [4:0] a, input logic [31:0] d);
    wr1_en = 1'b1; wr1_addr = a; wr1_data = d;
  endtask

  task automatic drive_iss(input logic [4:0] a);
    iss_en = 1'b1; iss_addr = a;
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model for the sweep (instance a) ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a)) return 32'd0;
    return {31'b0, m_busy[a]};
  endfunction

  task automatic model_update();
    if (wr0_en && wr0_addr != 5'd0) begin
      m_regs[wr0_addr] = wr0_data;
      m_busy[wr0_addr] = 1'b0;
    end
    if (wr1_en && wr1_addr != 5'd0) begin
      m_regs[wr1_addr] = wr1_data;
      m_busy[wr1_addr] = 1'b0;
    end
    if (iss_en && iss_addr != 5'd0) begin
      m_busy[iss_addr] = 1'b1;
    end
  endtask

  function automatic logic [4:0] rand_idx();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    idle();

    // Reset state
    #12;
    for (int i = 0; i < 4; i++) begin
      check("reset_rd_a", rda(i), 32'd0);
      check("reset_busy_a", bsa(i), 32'd0);
    end
    check("reset_rd_b", rdb(0), 32'd0);
    check("reset_busy_b", bsb(0), 32'd0);
    rst_n = 1'b1;
    step();

    // Asynchronous reset mid-cycle clears data and busy immediately
    drive_wr0(5'd5, 32'hDEAD);
    drive_iss(5'd5);
    step();
    idle();
    set_rda(0, 5'd5);
    set_rdb(0, 5'd5);
    #1;
    check("pre_rst_rd_a", rda(0), 32'hDEAD);
    check("pre_rst_busy_a", bsa(0), 32'd1);
    check("pre_rst_rd_b", rdb(0), 32'hDEAD);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_rd_a", rda(0), 32'd0);
    check("async_rst_busy_a", bsa(0), 32'd0);
    check("async_rst_rd_b", rdb(0), 32'd0);
    check("async_rst_busy_b", bsb(0), 32'd0);
    #1 rst_n = 1'b1;
    #1;
    check("post_rst_r5_a", rda(0), 32'd0);
    check("post_rst_r5_b", rdb(0), 32'd0);
    check("post_rst_busy_a", bsa(0), 32'd0);

    // Write in flight while reset is asserted is discarded
    step();
    drive_wr0(5'd8, 32'h77);
    #1 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    set_rda(1, 5'd8);
    #1;
    check("rst_mid_write_r8", rda(1), 32'd0);

    // Dual write to the same index: wr1 wins (bypass and array)
    drive_wr0(5'd3, 32'h11);
    drive_wr1(5'd3, 32'h22);
    set_rda(0, 5'd3);
    set_rdb(0, 5'd3);
    #1;
    check("dual_same_byp_a", rda(0), 32'h22);
    check("dual_same_nobyp_b", rdb(0), 32'd0);
    step();
    idle();
    #1;
    check("dual_same_r3_a", rda(0), 32'h22);
    check("dual_same_r3_b", rdb(0), 32'h22);

    // Dual write to different indices
    drive_wr0(5'd4, 32'h1);
    drive_wr1(5'd6, 32'h2);
    step();
    idle();
    set_rda(1, 5'd4);
    set_rda(2, 5'd6);
    #1;
    check("dual_diff_r4", rda(1), 32'h1);
    check("dual_diff_r6", rda(2), 32'h2);
    check("dual_diff_r3", rda(0), 32'h22);

    // Bypass vs. array latency
    drive_wr0(5'd7, 32'h33);
    step();
    idle();
    drive_wr0(5'd7, 32'h55);
    set_rda(3, 5'd7);
    set_rdb(1, 5'd7);
    #1;
    check("bypass_r7_a", rda(3), 32'h55);
    check("nobypass_old_r7_b", rdb(1), 32'h33);
    step();
    idle();
    #1;
    check("nobypass_new_r7_b", rdb(1), 32'h55);

    // Zero register
    drive_wr0(5'd0, 32'hFFFF);
    drive_iss(5'd0);
    set_rda(0, 5'd0);
    set_rdb(0, 5'd0);
    #1;
    check("zero_byp_rd_a", rda(0), 32'd0);
    check("zero_byp_busy_a", bsa(0), 32'd0);
    check("zero_off_old_b", rdb(0), 32'd0);
    step();
    idle();
    #1;
    check("zero_rd_a", rda(0), 32'd0);
    check("zero_busy_a", bsa(0), 32'd0);
    check("zero_off_rd_b", rdb(0), 32'hFFFF);
    check("zero_off_busy_b", bsb(0), 32'd1);

    // Scoreboard
    drive_iss(5'd9);
    step();
    idle();
    set_rda(2, 5'd9);
    set_rdb(1, 5'd9);
    #1;
    check("sb_iss_busy_a", bsa(2), 32'd1);
    check("sb_iss_busy_b", bsb(1), 32'd1);
    drive_wr0(5'd9, 32'h99);
    #1;
    check("sb_wr_byp_busy_a", bsa(2), 32'd0);
    check("sb_wr_byp_rd_a", rda(2), 32'h99);
    check("sb_wr_nobyp_busy_b", bsb(1), 32'd1);
    check("sb_wr_nobyp_rd_b", rdb(1), 32'd0);
    step();
    idle();
    #1;
    check("sb_clr_busy_a", bsa(2), 32'd0);
    check("sb_clr_busy_b", bsb(1), 32'd0);
    check("sb_clr_rd_b", rdb(1), 32'h99);
    drive_iss(5'd9);
    drive_wr0(5'd9, 32'hAA);
    step();
    idle();
    #1;
    check("sb_set_wins_busy", bsa(2), 32'd1);
    check("sb_set_wins_rd", rda(2), 32'hAA);
    drive_iss(5'd9);
    step();
    idle();
    #1;
    check("sb_reissue_busy", bsa(2), 32'd1);
    drive_wr1(5'd9, 32'hBB);
    #1;
    check("sb_wr1_byp_busy", bsa(2), 32'd0);
    check("sb_wr1_byp_rd", rda(2), 32'hBB);
    step();
    idle();
    #1;
    check("sb_single_bit_clr", bsa(2), 32'd0);

    // Sweep on instance a against the reference model, starting from a clean reset
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int n = 0; n < 32; n++) m_regs[n] = '0;
    m_busy = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      wr0_en   = ($urandom_range(0, 1) == 1);
      wr0_addr = rand_idx();
      wr0_data = $urandom;
      wr1_en   = ($urandom_range(0, 2) == 0);
      wr1_addr = rand_idx();
      wr1_data = $urandom;
      iss_en   = ($urandom_range(0, 1) == 1);
      iss_addr = rand_idx();
      for (int i = 0; i < 4; i++) set_rda(i, rand_idx());
      #1;
      for (int i = 0; i < 4; i++) begin
        check("sweep_rd", rda(i), exp_data(rd_addr_a[i*5 +: 5]));
        check("sweep_busy", bsa(i), exp_busy(rd_addr_a[i*5 +: 5]));
      end
      model_update();
      step();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
